muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the execute stage.
- Accepts one M-extension op per start pulse, runs a radix-2 shift-add or shift-subtract loop over XLEN cycles, and returns a registered result with a one-cycle done pulse.
- The pipeline stalls on busy, and flush aborts the operation.

Parameters:
XLEN, 32, operand/result width; power of two, at least 8; cycle counter width is clog2(XLEN).

Ports:
- clk_in  input  1  system clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  request; accepted only when busy_out=0
- funct3_in  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  input  XLEN  operand A (multiplicand / dividend)
- rs2_val  input  XLEN  operand B (multiplier / divisor)
- flush_in  input  1  abort current op; no done
- busy_out  output  1  high from acceptance edge until done_out falls
- done_out  output  1  one-cycle pulse; result_out valid this cycle
- result_out  output  XLEN  registered result; held until next accepted start

Behaviour:
- Reset (async, rst_n_in=0): state IDLE, busy_out=0, done_out=0, result_out=0, counter=0. Reset mid-operation discards all work.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start_in=1 and flush_in=0 at edge k latches funct3, operands (absolute values for signed forms), and the result signs.
  - Next state is CALC, or DONE for the special cases below.
  - busy_out=1 from edge k.
- CALC: exactly XLEN cycles, counter 0..XLEN-1.
  - Multiply: 2*XLEN-bit product register; add-and-shift per cycle.
  - Divide: restoring shift-subtract; one quotient bit per cycle.
  - At counter=XLEN-1, go to FIX.
- FIX: one cycle.
  - Apply sign correction: negate the product if the operand signs differ; negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the result: low half for MUL, high half for MULH/MULHSU/MULHU; quotient for DIV/DIVU, remainder for REM/REMU.
  - Write result_out, then go to DONE.
- DONE: done_out=1 for one cycle, busy_out=1, then IDLE.
- Latency: start accepted at edge k means done_out is high in the cycle following edge k+XLEN+2 (34 cycles for XLEN=32).
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU and DIVU/REMU: unsigned.
  - DIV/REM: signed.
- Special cases: skip CALC/FIX, write result_out at the acceptance edge, and go directly to DONE, so done_out is high after edge k+1.
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (DIV/REM with rs1=-2^(XLEN-1), rs2=-1): DIV gives -2^(XLEN-1); REM gives 0.
- start_in while busy_out=1: ignored; no queueing.
- flush_in=1 in any non-IDLE state: next edge enters IDLE with busy_out=0. No done_out; result_out keeps its previous value.
- flush_in=1 in DONE: done_out is still high that cycle, since it is already registered.
- flush_in and start_in together in IDLE: flush wins; the start is not accepted.
- start_in in the DONE cycle: ignored, because busy_out=1.
- Back-to-back operation: the earliest next acceptance is the cycle after DONE.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - All four multiply ops compute the full 2*XLEN product combinationally with a signed/unsigned * operator at acceptance.
  - Path is IDLE to FIX to DONE; done_out is high after edge k+2.
  - Division is unchanged.
- Undefined: multiplies use the iterative CALC path with XLEN+2 latency. No multiplier is inferred.

Test Plan:
- MUL 7 * -3 (rs1=0x00000007, rs2=0xFFFFFFFD) -> result 0xFFFFFFEB; done 34 cycles after start (2 with MULDIV_FAST_MUL_EN); busy high throughout.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2; each done after 34 cycles.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 % 0 -> 5, both with done after 1 cycle. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM of the same -> 0, both with done after 1 cycle.
- Abort and ignore:
  - Start DIV, assert flush at cycle 10 -> busy low next cycle, no done, result_out unchanged.
  - Start asserted while busy -> ignored; the original result completes correctly.
- rst_n_in low at CALC cycle 15 -> busy/done/result read 0 immediately; after release, a new MUL 3*4 -> 12.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// A start pulse in IDLE latches the operation and the operand magnitudes. XLEN
// radix-2 shift-add (multiply) or restoring shift-subtract (divide) steps then
// run in CALC. FIX applies the sign correction and selects the result, and
// done_out pulses for one cycle.
// Divide-by-zero and signed overflow skip straight to DONE.
// Optional feature macro: MULDIV_FAST_MUL_EN. When it is defined, all four
// multiply ops form the full product with a single '*' at acceptance and take
// the path IDLE -> FIX -> DONE.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            start_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] acc;
    logic              neg_main;
    logic              neg_rem;

    logic              in_is_div;
    logic              in_signed_a;
    logic              in_signed_b;
    logic              in_neg_a;
    logic              in_neg_b;
    logic [XLEN-1:0]   in_mag_a;
    logic [XLEN-1:0]   in_mag_b;
    logic              in_div_zero;
    logic              in_overflow;
    logic [XLEN-1:0]   in_special;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;
    logic [XLEN-1:0]   fix_result;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN+1:0] fast_prod;

    // Sign- or zero-extend each operand so a single signed multiply covers all four multiply forms
    always_comb begin
        fast_a    = {in_signed_a & rs1_val[XLEN-1], rs1_val};
        fast_b    = {in_signed_b & rs2_val[XLEN-1], rs2_val};
        fast_prod = fast_a * fast_b;
    end
`endif

    // Decode the incoming request: per-operand signedness, magnitudes and the special divide cases
    always_comb begin
        in_is_div = funct3_in[2];
        if (in_is_div) begin
            in_signed_a = ~funct3_in[0];
            in_signed_b = ~funct3_in[0];
        end else begin
            in_signed_a = (funct3_in[1:0] != 2'b11);
            in_signed_b = (funct3_in[1:0] == 2'b00) || (funct3_in[1:0] == 2'b01);
        end
        in_neg_a    = in_signed_a & rs1_val[XLEN-1];
        in_neg_b    = in_signed_b & rs2_val[XLEN-1];
        in_mag_a    = in_neg_a ? -rs1_val : rs1_val;
        in_mag_b    = in_neg_b ? -rs2_val : rs2_val;
        in_div_zero = in_is_div && (rs2_val == '0);
        in_overflow = in_is_div && !funct3_in[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
        if (in_div_zero) begin
            in_special = funct3_in[1] ? rs1_val : '1;
        end else begin
            in_special = funct3_in[1] ? '0 : MIN_NEG;
        end
    end

    // One radix-2 step for each algorithm. The upper half of acc holds the partial product or remainder; the lower half holds the multiplier or the quotient bits
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : '0)};
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result selection applied in FIX
    always_comb begin
        mul_full  = neg_main ? -acc : acc;
        quo_fixed = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fixed = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!op[2]) begin
            fix_result = (op[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        end else begin
            fix_result = op[1] ? rem_fixed : quo_fixed;
        end
    end

    // Sequencer FSM with registered busy, done and result outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            count      <= '0;
            op         <= '0;
            operand    <= '0;
            acc        <= '0;
            neg_main   <= 1'b0;
            neg_rem    <= 1'b0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            result_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (busy_out) begin
                        done_out <= 1'b0;
                        busy_out <= 1'b0;
                    end else if (start_in && !flush_in) begin
                        op       <= funct3_in;
                        busy_out <= 1'b1;
                        count    <= '0;
                        neg_main <= in_neg_a ^ in_neg_b;
                        neg_rem  <= in_neg_a;
                        if (in_div_zero || in_overflow) begin
                            result_out <= in_special;
                            state      <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!in_is_div) begin
                            acc      <= fast_prod[2*XLEN-1:0];
                            neg_main <= 1'b0;
                            state    <= FIX;
`endif
                        end else begin
                            operand <= in_is_div ? in_mag_b : in_mag_a;
                            acc     <= {{XLEN{1'b0}}, (in_is_div ? in_mag_a : in_mag_b)};
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                        count    <= '0;
                    end else begin
                        acc <= op[2] ? div_next : mul_next;
                        if (count == CW'(XLEN-1)) begin
                            count <= '0;
                            state <= FIX;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                FIX: begin
                    if (flush_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        result_out <= fix_result;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done_out <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                    done_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq (XLEN=32). A transaction-level
// model predicts busy/done timing and the result from plain 64-bit arithmetic.
// A single negedge compare process checks the outputs against that model on
// every cycle. Test-plan vectors also carry hand-computed literal results.
module tb_muldiv_seq;

    logic        clk_in;
    logic        rst_n_in;
    logic        start_in;
    logic [2:0]  funct3_in;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush_in;
    logic        busy_out;
    logic        done_out;
    logic [31:0] result_out;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    bit          model_active = 0;
    int          acc_edge = 0;
    int          done_edge = 0;
    logic [31:0] pending = '0;
    logic [31:0] committed = '0;
    bit          lit_valid = 0;
    logic [31:0] lit_expect = '0;
    string       lit_name = "";

    muldiv_seq #(.XLEN(32)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .start_in  (start_in),
        .funct3_in (funct3_in),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .flush_in  (flush_in),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .result_out(result_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Architectural result of an M-extension op, computed with plain 64-bit arithmetic
    function automatic logic [31:0] model_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          ua;
        longint          ub;
        longint          p;
        logic [63:0]     pu;
        int              qa;
        int              qb;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
            3'd4: begin
                qa = $signed(a);
                qb = $signed(b);
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = qa / qb;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                qa = $signed(a);
                qb = $signed(b);
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = qa % qb;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        if (ua < 0 || ub < 0) r = '0;
        return r;
    endfunction

    // Cycles from acceptance edge to the edge after which done_out is high
    function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 2;
`endif
        return 34;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cyc, actual, expected);
        end
    endtask

    // Compare process: every cycle check busy/done, and result whenever it must be stable
    always @(negedge clk_in) begin
        logic        exp_busy;
        logic        exp_done;
        logic [31:0] exp_res;
        if (!rst_n_in) begin
            checkOutput("reset_busy", {31'd0, busy_out}, 32'd0);
            checkOutput("reset_done", {31'd0, done_out}, 32'd0);
            checkOutput("reset_result", result_out, 32'd0);
        end else begin
            exp_busy = model_active && cyc >= acc_edge && cyc <= done_edge;
            exp_done = model_active && cyc == done_edge;
            exp_res  = (model_active && cyc >= done_edge) ? pending : committed;
            checkOutput("busy", {31'd0, busy_out}, {31'd0, exp_busy});
            checkOutput("done", {31'd0, done_out}, {31'd0, exp_done});
            if (exp_done || !exp_busy) checkOutput("result", result_out, exp_res);
            if (exp_done && lit_valid) checkOutput(lit_name, result_out, lit_expect);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // abort_kind: 0 none, 1 flush at abort_at cycles after acceptance, 2 reset at CALC cycle abort_at.
    // poke: also pulse start_in mid-operation and in the done cycle; both must be ignored.
    task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] lit,
                                 input int abort_kind, input int abort_at, input bit poke);
        bit stop;
        start_in  = 1'b1;
        funct3_in = f3;
        rs1_val   = a;
        rs2_val   = b;
        tick();
        start_in     = 1'b0;
        acc_edge     = cyc;
        done_edge    = cyc + model_latency(f3, a, b);
        pending      = model_op(f3, a, b);
        lit_expect   = lit;
        lit_name     = name;
        lit_valid    = (abort_kind == 0);
        model_active = 1'b1;
        stop = 1'b0;
        while (!stop && cyc <= done_edge) begin
            if (poke && (cyc == acc_edge + 5 || cyc == done_edge)) begin
                start_in  = 1'b1;
                funct3_in = 3'd5;
                rs1_val   = 32'd999;
                rs2_val   = 32'd10;
            end else begin
                start_in = 1'b0;
            end
            if (abort_kind == 2 && cyc == acc_edge + abort_at) begin
                rst_n_in     = 1'b0;
                model_active = 1'b0;
                committed    = '0;
                lit_valid    = 1'b0;
                tick();
                tick();
                rst_n_in = 1'b1;
                stop = 1'b1;
            end else if (abort_kind == 1 && cyc == acc_edge + abort_at - 1) begin
                flush_in = 1'b1;
                tick();
                flush_in     = 1'b0;
                model_active = 1'b0;
                lit_valid    = 1'b0;
                stop = 1'b1;
            end else begin
                tick();
            end
        end
        start_in = 1'b0;
        if (model_active) begin
            committed    = pending;
            model_active = 1'b0;
            lit_valid    = 1'b0;
        end
        tick();
    endtask

    initial begin
        rst_n_in  = 1'b0;
        start_in  = 1'b0;
        flush_in  = 1'b0;
        funct3_in = '0;
        rs1_val   = '0;
        rs2_val   = '0;
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();

        $display("[TB] multiply vectors");
        applyStimulus("mul_7_m3",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0, 0);
        applyStimulus("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0, 0);
        applyStimulus("mulhu_ones",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0);
        applyStimulus("mulhsu_ones",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        applyStimulus("mul_ffff_sq",  3'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 0, 0, 0);
        applyStimulus("mulh_m1_5",    3'd1, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 0, 0, 0);

        $display("[TB] divide vectors");
        applyStimulus("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, 0);
        applyStimulus("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0, 0);
        applyStimulus("divu_100_7",   3'd5, 32'd100, 32'd7, 32'd14, 0, 0, 0);
        applyStimulus("remu_100_7",   3'd7, 32'd100, 32'd7, 32'd2, 0, 0, 0);
        applyStimulus("div_7_m2",     3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0, 0);
        applyStimulus("rem_7_m2",     3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 0, 0, 0);
        applyStimulus("divu_max_1",   3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, 0, 0);

        $display("[TB] special cases");
        applyStimulus("divu_5_0",     3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
        applyStimulus("rem_5_0",      3'd6, 32'd5, 32'd0, 32'd5, 0, 0, 0);
        applyStimulus("remu_7_0",     3'd7, 32'd7, 32'd0, 32'd7, 0, 0, 0);
        applyStimulus("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0);
        applyStimulus("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0, 0);

        $display("[TB] abort and ignore");
        applyStimulus("mul_poke",     3'd0, 32'd3, 32'd5, 32'd15, 0, 0, 1);
        applyStimulus("div_flush",    3'd4, 32'd1000, 32'd3, 32'd0, 1, 10, 0);
        start_in  = 1'b1;
        flush_in  = 1'b1;
        funct3_in = 3'd0;
        rs1_val   = 32'd9;
        rs2_val   = 32'd9;
        tick();
        start_in = 1'b0;
        flush_in = 1'b0;
        tick();
        tick();
        tick();

        $display("[TB] reset mid-operation");
        applyStimulus("mul_reset",    3'd0, 32'h0000_1234, 32'h0000_0010, 32'd0, 2, 15, 0);
        tick();
        applyStimulus("mul_3_4",      3'd0, 32'd3, 32'd4, 32'd12, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
